rs_mul: RTL and testbench

- Reservation station feeding the multiply execution unit.
- Accepts decoded multiply ops from dispatch and holds them until both source operands are valid.
- Snoops the common data bus (CDB) to capture pending operands.
- Issues the oldest ready entry to the multiply unit using its valid/accessable issue interface.

---
 rtl/rs_mul_if.sv | 50 +++++
 rtl/rs_mul.sv | 162 ++++++++++++++++
 tb/tb_rs_mul.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rs_mul_if.sv
// rs_mul_if: dispatch, CDB snoop and issue signals of the multiply reservation station.
//   slave  : the reservation station (consumes dispatch/CDB, drives issue + dp_rdy)
//   master : the environment (dispatch stage, CDB, multiply unit)
interface rs_mul_if #(
  parameter int TAG_WIDTH = 6,
  parameter int DATA_W    = 32
);
  logic                 i_flush;
  logic                 i_dp_vld;
  logic                 o_dp_rdy;
  logic                 i_dp_signed1;
  logic                 i_dp_signed2;
  logic                 i_dp_sel_high;
  logic [DATA_W-1:0]    i_dp_src1;
  logic                 i_dp_src1_vld;
  logic [TAG_WIDTH-1:0] i_dp_src1_tag;
  logic [DATA_W-1:0]    i_dp_src2;
  logic                 i_dp_src2_vld;
  logic [TAG_WIDTH-1:0] i_dp_src2_tag;
  logic [TAG_WIDTH-1:0] i_dp_dst_tag;
  logic                 i_cdb_vld;
  logic [TAG_WIDTH-1:0] i_cdb_tag;
  logic [DATA_W-1:0]    i_cdb_data;
  logic                 i_ex_accessable;
  logic                 o_is_vld;
  logic                 o_is_signed1;
  logic                 o_is_signed2;
  logic                 o_is_sel_high;
  logic [DATA_W-1:0]    o_is_src1;
  logic [DATA_W-1:0]    o_is_src2;
  logic [TAG_WIDTH-1:0] o_is_dst_tag;

  modport slave (
    input  i_flush, i_dp_vld, i_dp_signed1, i_dp_signed2, i_dp_sel_high,
           i_dp_src1, i_dp_src1_vld, i_dp_src1_tag,
           i_dp_src2, i_dp_src2_vld, i_dp_src2_tag, i_dp_dst_tag,
           i_cdb_vld, i_cdb_tag, i_cdb_data, i_ex_accessable,
    output o_dp_rdy, o_is_vld, o_is_signed1, o_is_signed2, o_is_sel_high,
           o_is_src1, o_is_src2, o_is_dst_tag
  );

  modport master (
    output i_flush, i_dp_vld, i_dp_signed1, i_dp_signed2, i_dp_sel_high,
           i_dp_src1, i_dp_src1_vld, i_dp_src1_tag,
           i_dp_src2, i_dp_src2_vld, i_dp_src2_tag, i_dp_dst_tag,
           i_cdb_vld, i_cdb_tag, i_cdb_data, i_ex_accessable,
    input  o_dp_rdy, o_is_vld, o_is_signed1, o_is_signed2, o_is_sel_high,
           o_is_src1, o_is_src2, o_is_dst_tag
  );
endinterface

// File: rtl/rs_mul.sv
// rs_mul: reservation station in front of the multiply unit.
//   Holds up to DEPTH dispatched multiply ops, snoops the CDB for missing
//   operands, and issues the oldest ready op when the unit is accessable.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rs_mul_if.slave (flush, dispatch, CDB, issue)
// Optional feature macro: RS_MUL_WAKEUP_BYPASS_EN
//   defined   -> an operand matching the live CDB counts as ready this cycle and
//                the issue mux forwards i_cdb_data (0-cycle wakeup-to-issue)
//   undefined -> readiness from registered state only (1-cycle wakeup-to-issue)
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif

module rs_mul #(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 6
) (
  input  logic   clk,
  input  logic   rst,
  rs_mul_if.slave bus
);
  localparam int DW   = `RV32_DATA_WIDTH;
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                 s1;
    logic                 s2;
    logic                 sh;
    logic [DW-1:0]        a;
    logic                 a_rdy;
    logic [TAG_WIDTH-1:0] a_tag;
    logic [DW-1:0]        b;
    logic                 b_rdy;
    logic [TAG_WIDTH-1:0] b_tag;
    logic [TAG_WIDTH-1:0] dst;
  } ent_t;

  ent_t                        ent_q [DEPTH];
  ent_t                        ent_d [DEPTH];
  logic [DEPTH-1:0]            vld_q, vld_d;
  // older_q[j][i] = entry j was dispatched before entry i
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

  logic [DEPTH-1:0] a_hit, b_hit, rdy, pick;
  logic [IDXW-1:0]  sel, free;
  logic             any_rdy, is_fire, dp_rdy, dp_fire;
  logic             dp_a_hit, dp_b_hit;
  ent_t             sel_e, new_e;

  // wakeup / readiness / oldest-ready selection
  always_comb begin
    a_hit = '0;
    b_hit = '0;
    rdy   = '0;
    pick  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      a_hit[i] = bus.i_cdb_vld && (ent_q[i].a_tag == bus.i_cdb_tag);
      b_hit[i] = bus.i_cdb_vld && (ent_q[i].b_tag == bus.i_cdb_tag);
`ifdef RS_MUL_WAKEUP_BYPASS_EN
      rdy[i] = vld_q[i] && (ent_q[i].a_rdy || a_hit[i]) && (ent_q[i].b_rdy || b_hit[i]);
`else
      rdy[i] = vld_q[i] && ent_q[i].a_rdy && ent_q[i].b_rdy;
`endif
    end
    // an entry is picked when no other ready entry is older than it
    for (int i = 0; i < DEPTH; i++) begin
      logic blk;
      blk = 1'b0;
      for (int j = 0; j < DEPTH; j++)
        blk = blk | (rdy[j] & older_q[j][i]);
      pick[i] = rdy[i] & ~blk;
    end
  end

  always_comb begin
    sel  = '0;
    free = '0;
    for (int i = 0; i < DEPTH; i++)
      if (pick[i]) sel = IDXW'(i);
    for (int i = DEPTH-1; i >= 0; i--)
      if (!vld_q[i]) free = IDXW'(i);
  end

  assign any_rdy = |rdy;
  assign is_fire = any_rdy & bus.i_ex_accessable & ~bus.i_flush;
  assign dp_rdy  = ~&vld_q;
  assign dp_fire = bus.i_dp_vld & dp_rdy & ~bus.i_flush;
  assign sel_e   = ent_q[sel];

  // issue outputs: zero when nothing is ready
  always_comb begin
    bus.o_is_vld      = is_fire;
    bus.o_is_signed1  = any_rdy & sel_e.s1;
    bus.o_is_signed2  = any_rdy & sel_e.s2;
    bus.o_is_sel_high = any_rdy & sel_e.sh;
    bus.o_is_dst_tag  = any_rdy ? sel_e.dst : '0;
`ifdef RS_MUL_WAKEUP_BYPASS_EN
    bus.o_is_src1 = !any_rdy ? '0 : (sel_e.a_rdy ? sel_e.a : bus.i_cdb_data);
    bus.o_is_src2 = !any_rdy ? '0 : (sel_e.b_rdy ? sel_e.b : bus.i_cdb_data);
`else
    bus.o_is_src1 = any_rdy ? sel_e.a : '0;
    bus.o_is_src2 = any_rdy ? sel_e.b : '0;
`endif
  end
  assign bus.o_dp_rdy = dp_rdy;

  // incoming entry, capturing a matching broadcast in the dispatch cycle
  assign dp_a_hit = !bus.i_dp_src1_vld && bus.i_cdb_vld && (bus.i_dp_src1_tag == bus.i_cdb_tag);
  assign dp_b_hit = !bus.i_dp_src2_vld && bus.i_cdb_vld && (bus.i_dp_src2_tag == bus.i_cdb_tag);
  always_comb begin
    new_e.s1    = bus.i_dp_signed1;
    new_e.s2    = bus.i_dp_signed2;
    new_e.sh    = bus.i_dp_sel_high;
    new_e.a     = dp_a_hit ? bus.i_cdb_data : bus.i_dp_src1;
    new_e.a_rdy = bus.i_dp_src1_vld | dp_a_hit;
    new_e.a_tag = bus.i_dp_src1_tag;
    new_e.b     = dp_b_hit ? bus.i_cdb_data : bus.i_dp_src2;
    new_e.b_rdy = bus.i_dp_src2_vld | dp_b_hit;
    new_e.b_tag = bus.i_dp_src2_tag;
    new_e.dst   = bus.i_dp_dst_tag;
  end

  always_comb begin
    ent_d   = ent_q;
    vld_d   = vld_q;
    older_d = older_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !ent_q[i].a_rdy && a_hit[i]) begin
        ent_d[i].a     = bus.i_cdb_data;
        ent_d[i].a_rdy = 1'b1;
      end
      if (vld_q[i] && !ent_q[i].b_rdy && b_hit[i]) begin
        ent_d[i].b     = bus.i_cdb_data;
        ent_d[i].b_rdy = 1'b1;
      end
    end
    if (is_fire) vld_d[sel] = 1'b0;
    // free slot is never the issuing slot, so both updates coexist
    if (dp_fire) begin
      ent_d[free] = new_e;
      vld_d[free] = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
        older_d[j][free] = vld_q[j];
        older_d[free][j] = 1'b0;
      end
    end
    if (bus.i_flush) vld_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      older_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      vld_q   <= vld_d;
      older_q <= older_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end
endmodule

// File: tb/tb_rs_mul.sv
// tb_rs_mul: directed + random stimulus against an in-order queue model of the
// reservation station (oldest-first list, removal on issue).
module tb_rs_mul;
  localparam int DEPTH = 4;
  localparam int TW    = 6;
  localparam int DW    = 32;
`ifdef RS_MUL_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    bit          s1, s2, sh;
    bit [DW-1:0] a, b;
    bit          ar, br;
    bit [TW-1:0] at, bt, dst;
  } m_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  m_t   mq[$];

  rs_mul_if #(.TAG_WIDTH(TW), .DATA_W(DW)) bus ();
  rs_mul #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.i_flush = 0; bus.i_dp_vld = 0; bus.i_dp_signed1 = 0; bus.i_dp_signed2 = 0;
    bus.i_dp_sel_high = 0; bus.i_dp_src1 = 0; bus.i_dp_src1_vld = 0; bus.i_dp_src1_tag = 0;
    bus.i_dp_src2 = 0; bus.i_dp_src2_vld = 0; bus.i_dp_src2_tag = 0; bus.i_dp_dst_tag = 0;
    bus.i_cdb_vld = 0; bus.i_cdb_tag = 0; bus.i_cdb_data = 0; bus.i_ex_accessable = 1;
  endtask

  task automatic dp(input bit s1, input bit s2, input bit sh,
                    input bit [DW-1:0] a, input bit av, input bit [TW-1:0] at,
                    input bit [DW-1:0] b, input bit bv, input bit [TW-1:0] bt,
                    input bit [TW-1:0] dst);
    bus.i_dp_vld = 1; bus.i_dp_signed1 = s1; bus.i_dp_signed2 = s2; bus.i_dp_sel_high = sh;
    bus.i_dp_src1 = a; bus.i_dp_src1_vld = av; bus.i_dp_src1_tag = at;
    bus.i_dp_src2 = b; bus.i_dp_src2_vld = bv; bus.i_dp_src2_tag = bt;
    bus.i_dp_dst_tag = dst;
  endtask

  task automatic cdb(input bit v, input bit [TW-1:0] t, input bit [DW-1:0] d);
    bus.i_cdb_vld = v; bus.i_cdb_tag = t; bus.i_cdb_data = d;
  endtask

  function automatic bit hit(input bit [TW-1:0] t);
    return bus.i_cdb_vld && bus.i_cdb_tag == t;
  endfunction

  // one clock: check outputs at negedge, advance the model at posedge
  task automatic cyc();
    bit exp_rdy, exp_vld;
    int idx;
    m_t e, n;
    @(negedge clk);
    exp_rdy = mq.size() < DEPTH;
    idx = -1;
    foreach (mq[k])
      if (idx < 0 && (mq[k].ar || (BYP && hit(mq[k].at))) && (mq[k].br || (BYP && hit(mq[k].bt))))
        idx = k;
    exp_vld = idx >= 0 && bus.i_ex_accessable && !bus.i_flush;
    chk("dp_rdy", bus.o_dp_rdy, exp_rdy);
    chk("is_vld", bus.o_is_vld, exp_vld);
    if (exp_vld) begin
      e = mq[idx];
      chk("is_src1", bus.o_is_src1, e.ar ? e.a : bus.i_cdb_data);
      chk("is_src2", bus.o_is_src2, e.br ? e.b : bus.i_cdb_data);
      chk("is_dst", bus.o_is_dst_tag, e.dst);
      chk("is_flags", {bus.o_is_signed1, bus.o_is_signed2, bus.o_is_sel_high}, {e.s1, e.s2, e.sh});
    end
    @(posedge clk);
    if (bus.i_flush) mq.delete();
    else begin
      if (exp_vld) mq.delete(idx);
      foreach (mq[k]) begin
        if (!mq[k].ar && hit(mq[k].at)) begin mq[k].a = bus.i_cdb_data; mq[k].ar = 1; end
        if (!mq[k].br && hit(mq[k].bt)) begin mq[k].b = bus.i_cdb_data; mq[k].br = 1; end
      end
      if (bus.i_dp_vld && exp_rdy) begin
        n.s1 = bus.i_dp_signed1; n.s2 = bus.i_dp_signed2; n.sh = bus.i_dp_sel_high;
        n.at = bus.i_dp_src1_tag; n.bt = bus.i_dp_src2_tag; n.dst = bus.i_dp_dst_tag;
        n.ar = bus.i_dp_src1_vld || hit(n.at);
        n.a  = bus.i_dp_src1_vld ? bus.i_dp_src1 : bus.i_cdb_data;
        n.br = bus.i_dp_src2_vld || hit(n.bt);
        n.b  = bus.i_dp_src2_vld ? bus.i_dp_src2 : bus.i_cdb_data;
        mq.push_back(n);
      end
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    #12;
    chk("rst_is_vld", bus.o_is_vld, 1'b0);
    chk("rst_dp_rdy", bus.o_dp_rdy, 1'b1);
    @(posedge clk); #1; rst = 0;

    // basic: both ready, issue next cycle then idle
    dp(1, 0, 0, 3, 1, 0, 5, 1, 0, 7); cyc();
    idle(); cyc(); cyc();

    // src2 waits on tag 9, CDB two cycles later
    dp(0, 1, 1, $urandom, 1, 0, 0, 0, 9, 12); cyc();
    idle(); cyc();
    cdb(1, 9, 32'h10); cyc();
    idle(); cyc(); cyc();

    // fill with pending ops, fifth ignored, wake one and drain
    for (int i = 0; i < 4; i++) begin
      dp(i[0], 0, 0, 0, 0, TW'(20 + i), $urandom, 1, 0, TW'(30 + i)); cyc();
    end
    dp(0, 0, 0, 1, 1, 0, 2, 1, 0, 40); cyc();
    idle(); cdb(1, 21, $urandom); cyc();
    idle(); cyc(); cyc();
    for (int i = 0; i < 4; i++) begin cdb(1, TW'(20 + i), $urandom); cyc(); end
    idle(); cyc(); cyc();

    // accessable held low, then A before B
    bus.i_ex_accessable = 0;
    dp(0, 0, 0, $urandom, 1, 0, $urandom, 1, 0, 1); cyc();
    dp(1, 1, 0, $urandom, 1, 0, $urandom, 1, 0, 2); cyc();
    idle(); bus.i_ex_accessable = 0; cyc();
    bus.i_ex_accessable = 1; cyc(); cyc(); cyc();

    // flush with concurrent dispatch
    for (int i = 0; i < 3; i++) begin
      dp(0, 0, 0, 0, 0, TW'(50 + i), 0, 1, 0, TW'(i)); cyc();
    end
    idle(); bus.i_flush = 1; dp(0, 0, 1, 11, 1, 0, 22, 1, 0, 33); cyc();
    idle(); cyc(); cyc();

    // async reset with three ready entries held
    bus.i_ex_accessable = 0;
    for (int i = 0; i < 3; i++) begin
      dp(0, 0, 0, $urandom, 1, 0, $urandom, 1, 0, TW'(i)); cyc();
    end
    idle();
    @(negedge clk); #2;
    rst = 1; bus.i_ex_accessable = 1;
    #1;
    chk("midrst_is_vld", bus.o_is_vld, 1'b0);
    chk("midrst_dp_rdy", bus.o_dp_rdy, 1'b1);
    mq.delete();
    @(posedge clk); #1; rst = 0;
    cyc(); cyc();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      bus.i_ex_accessable = ($urandom_range(3) != 0);
      bus.i_flush = ($urandom_range(40) == 0);
      cdb($urandom_range(1), TW'($urandom_range(7)), $urandom);
      if ($urandom_range(1))
        dp($urandom_range(1), $urandom_range(1), $urandom_range(1),
           $urandom, $urandom_range(2) != 0, TW'($urandom_range(7)),
           $urandom, $urandom_range(2) != 0, TW'($urandom_range(7)),
           TW'($urandom));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
